// File: rtl/muldiv_pkg.sv
// Shared types and op-classification helpers for the iterative M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // MUL is classed as signed: its low half is identical either way.
  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 step datapath: shift-add multiply and restoring shift-subtract divide
// sharing one (XLEN+1)-bit adder. Operates on unsigned magnitudes only.
module muldiv_iter_core
  #(parameter int XLEN = 32)
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   load_a,
    input  logic [XLEN-1:0]   load_b,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   divisor,
    output logic [2*XLEN-1:0] acc_step,
    output logic [XLEN-1:0]   quo_step,
    output logic [XLEN-1:0]   rem_step
  );

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;

  logic [XLEN:0] div_shift;
  logic [XLEN:0] add_a;
  logic [XLEN:0] add_b;
  logic [XLEN:0] sum;

  // Divide subtracts via inverted divisor plus carry-in; multiply adds the
  // multiplicand when the current multiplier bit (acc LSB) is set.
  always_comb begin
    div_shift = {rem_q, quo_q[XLEN-1]};
    add_a     = is_div ? div_shift : {1'b0, acc_q[2*XLEN-1:XLEN]};
    if (is_div) begin
      add_b = ~{1'b0, divisor};
    end else if (acc_q[0]) begin
      add_b = {1'b0, mcand};
    end else begin
      add_b = '0;
    end
    sum      = add_a + add_b + {{XLEN{1'b0}}, is_div};
    acc_step = {sum, acc_q[XLEN-1:1]};
    if (sum[XLEN]) begin
      rem_step = div_shift[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step = sum[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    acc_d = acc_q;
    quo_d = quo_q;
    rem_d = rem_q;
    if (load) begin
      acc_d = {{XLEN{1'b0}}, load_b};
      quo_d = load_a;
      rem_d = '0;
    end else if (step) begin
      if (is_div) begin
        quo_d = quo_step;
        rem_d = rem_step;
      end else begin
        acc_d = acc_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Multi-cycle RV M-extension unit: FSM, special cases, sign fix-up, handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divide stays iterative).
module muldiv_iter_unit
  import muldiv_pkg::*;
  #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
  );

  muldiv_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic [XLEN-1:0] mag_a_q, mag_a_d;
  logic [XLEN-1:0] mag_b_q, mag_b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;

  muldiv_op_e      in_op_e;
  logic            in_sign_a, in_sign_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic            fast_mul_hit;
  logic [XLEN-1:0] fast_res;

  logic              core_load, core_step;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   quo_step, rem_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign in_op_e   = muldiv_op_e'(in_op);
  assign in_sign_a = is_signed_a(in_op_e) & in_a[XLEN-1];
  assign in_sign_b = is_signed_b(in_op_e) & in_b[XLEN-1];
  assign in_mag_a  = in_sign_a ? -in_a : in_a;
  assign in_mag_b  = in_sign_b ? -in_b : in_b;

  assign div_zero = is_div(in_op_e) && (in_b == '0);
  assign div_ovf  = ((in_op_e == OP_DIV) || (in_op_e == OP_REM)) &&
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = ((in_op_e == OP_DIV) || (in_op_e == OP_DIVU)) ? '1 : in_a;
    end else if (div_ovf) begin
      special_res = (in_op_e == OP_DIV) ? in_a : '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;
  logic [1:0]               unused_fast_hi;

  // One extra bit per operand lets a single signed multiply cover all four flavours.
  assign fast_a         = {in_sign_a, in_a};
  assign fast_b         = {in_sign_b, in_b};
  assign fast_prod      = fast_a * fast_b;
  assign unused_fast_hi = fast_prod[2*XLEN+1:2*XLEN];
  assign fast_mul_hit   = !is_div(in_op_e);
  assign fast_res       = (in_op_e == OP_MUL) ? fast_prod[XLEN-1:0]
                                              : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul_hit = 1'b0;
  assign fast_res     = '0;
`endif

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .is_div   (is_div(op_q)),
    .load_a   (in_mag_a),
    .load_b   (in_mag_b),
    .mcand    (mag_a_q),
    .divisor  (mag_b_q),
    .acc_step (acc_step),
    .quo_step (quo_step),
    .rem_step (rem_step)
  );

  // Fix-up works on the final step's outputs so DONE carries the signed result.
  always_comb begin
    prod_fix = neg_res_q ? -acc_step : acc_step;
    quo_fix  = neg_res_q ? -quo_step : quo_step;
    rem_fix  = neg_rem_q ? -rem_step : rem_step;
    case (op_q)
      OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_res = quo_fix;
      default:                      calc_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    core_load = 1'b0;
    core_step = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = in_op_e;
            mag_a_d   = in_mag_a;
            mag_b_d   = in_mag_b;
            neg_res_d = in_sign_a ^ in_sign_b;
            neg_rem_d = in_sign_a;
            cnt_d     = '0;
            core_load = 1'b1;
            if (div_zero || div_ovf) begin
              res_d   = special_res;
              state_d = DONE;
            end else if (fast_mul_hit) begin
              res_d   = fast_res;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          core_step = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            res_d   = calc_res;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised, multi-cycle RV M-extension execution unit; the sequential successor to the single-cycle ALU M path.
- Covers all eight M ops, including MULHSU, on XLEN-bit operands.
- Computes through a shared radix-2 iterative datapath under a valid/ready handshake.
- Sits beside the ALU in EXU; the core stalls on in_ready/out_valid instead of closing timing through a combinational multiplier/divider.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  kill in-flight op; highest priority after reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  XLEN  rs1 operand.
- in_b  input  XLEN  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out_result  output  XLEN  result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values (async, rst_n low): state IDLE, counter 0, all datapath registers 0. Outputs: out_valid 0, out_result 0, in_ready 1, busy 0.
- Reset mid-operation abandons the op; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC when in_valid & in_ready (acceptance edge, cycle N). On that edge:
  - operands are registered as magnitudes, plus sign flags and op;
  - counter is cleared.
- IDLE -> DONE directly, with the result at cycle N+1, for:
  - divide-by-zero: DIV/DIVU give all-ones; REM/REMU give in_a;
  - signed overflow (in_a = 1<<(XLEN-1), in_b = all-ones): DIV gives in_a; REM gives 0.
- CALC:
  - one iteration per cycle, XLEN iterations;
  - multiply uses shift-add into a 2*XLEN accumulator; divide uses a restoring shift-subtract;
  - counter == XLEN-1 -> DONE.
  - Result is valid in cycle N+XLEN+1 (33 cycles for XLEN=32).
- Sign fix-up is applied when entering DONE, not as an extra cycle:
  - MUL/MULH: product negated if sign(a) != sign(b);
  - MULHSU: only a is treated as signed;
  - DIV: quotient negated if signs differ;
  - REM: remainder takes the sign of the dividend.
- Result selection:
  - MUL returns the low XLEN bits of the product;
  - MULH/MULHSU/MULHU return the high XLEN bits;
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE:
  - out_valid = 1; out_result is registered and held stable while out_ready = 0;
  - out_valid & out_ready -> IDLE;
  - no new request is accepted in the same cycle (in_ready is low in DONE).
- flush:
  - any state -> IDLE on the next edge; out_valid deasserts that edge;
  - flush & in_valid in IDLE: the request is not accepted.
- in_op is sampled only at acceptance; changes on in_op/in_a/in_b afterwards are ignored.
- Unused funct3 patterns are impossible (full 3-bit decode). No error output.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a combinational (XLEN+1)x(XLEN+1) signed product, registered on acceptance;
  - the unit goes straight to DONE; result at N+1;
  - divide remains iterative.
- Undefined:
  - all multiplies are iterative (XLEN+1 cycles);
  - no multiplier is inferred.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_e enum (the eight funct3 codes);
  - muldiv_state_e enum (IDLE/CALC/DONE);
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- Sub-module muldiv_iter_core: one-step shift-add / shift-subtract datapath (acc, quotient, remainder registers plus the step adder).
- muldiv_iter_unit keeps the FSM, counter, special-case detection, sign fix-up and handshake.

Test Plan:
- All four multiplies with a = b = 0xFFFFFFFF, out_ready = 1, XLEN=32:
  - MUL -> 0x00000001; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE;
  - out_valid at N+33 (N+1 with MULDIV_FAST_MUL_EN).
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2; each at N+33.
- Special cases, each at N+1:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid.
  - out_result and out_valid stay stable; in_ready stays 0; in_valid pulses are not accepted.
  - Handshake completes on the cycle out_ready rises; in_ready = 1 on the following cycle.
- flush at cycle N+10 of DIVU:
  - IDLE at N+11; no out_valid ever;
  - a following DIVU 9/3 -> 3 completes normally.
- rst_n low for 1 cycle mid-CALC:
  - all outputs return to reset values immediately (asynchronous), with no result emitted;
  - the next request is accepted after rst_n rises.
